// File: rtl/ips_spike_encoder.sv
// Purpose : Poisson-encodes N_IN pixel intensities into one spike bit each, using an LFSR random number per compare.
// Latency : start_ips sampled on edge 0; valid_ips pulses for one cycle after edge N_IN+1 (17 cycles at the defaults).
// Backpr. : none; the pixel memory answers every read, and start_ips outside IDLE is dropped, not queued.
//
// Ports:
//   clk, rst_n       single clock, asynchronous active-low reset
//   start_ips        one-cycle launch pulse, honoured only in IDLE
//   pix_rd/pix_addr  registered read request to the external pixel memory
//   pix_data         read data for the address presented on the previous edge
//   spike_vec        encoded spikes (bit i <- pixel i), held until the next launch
//   valid_ips        one-cycle done pulse
//   busy             high while a run is in progress
//   spike_cnt        number of ones in spike_vec (only with IPS_SPIKE_COUNT_EN defined)
//
// Build option: define IPS_SPIKE_COUNT_EN to add the spike_cnt output and its counter.

module ips_spike_encoder #(
    parameter int N_IN   = 16,
    parameter int ADDR_W = 4,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_ips,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [PIX_W-1:0]  pix_data,
    output logic [N_IN-1:0]   spike_vec,
    output logic              valid_ips,
    output logic              busy
`ifdef IPS_SPIKE_COUNT_EN
    ,
    output logic [15:0]       spike_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [15:0]       LFSR_SEED = 16'hACE1;
    localparam logic [15:0]       LFSR_TAPS = 16'hB400;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_IN - 1);

    state_t            state;
    state_t            state_nxt;
    logic              launch;
    logic              issue;
    logic              finish;
    logic [ADDR_W-1:0] issue_idx;

    logic [15:0]       lfsr;
    logic [15:0]       lfsr_nxt;
    logic [PIX_W-1:0]  rnd;
    logic              hit;

    // ------------------------------------------------------------------
    // FSM: state register + next-state / control decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        issue     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start_ips) begin
                    launch    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                issue = 1'b1;
                if (issue_idx == LAST_IDX) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read request generation. Outputs are registered, so the first
    // address appears one edge after the launch edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_idx <= '0;
            pix_rd    <= 1'b0;
            pix_addr  <= '0;
            busy      <= 1'b0;
            valid_ips <= 1'b0;
        end else begin
            valid_ips <= finish;
            if (launch) begin
                issue_idx <= '0;
            end
            if (issue) begin
                pix_rd    <= 1'b1;
                pix_addr  <= issue_idx;
                busy      <= 1'b1;
                issue_idx <= issue_idx + ADDR_W'(1);
            end
            if (finish) begin
                pix_rd <= 1'b0;
                busy   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare stage. pix_data belongs to the address registered on the
    // previous edge, and pix_rd/pix_addr still carry that request during
    // this cycle, so they directly qualify and steer the compare. This
    // keeps the compare one address behind the issue without extra
    // pipeline registers.
    // ------------------------------------------------------------------
    assign rnd      = lfsr[PIX_W-1:0];
    assign hit      = (pix_data > rnd);
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (pix_rd) begin
            lfsr <= lfsr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_vec <= '0;
        end else if (launch) begin
            spike_vec <= '0;
        end else if (pix_rd) begin
            for (int i = 0; i < N_IN; i++) begin
                if (pix_addr == ADDR_W'(i)) begin
                    spike_vec[i] <= hit;
                end
            end
        end
    end

`ifdef IPS_SPIKE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_cnt <= 16'd0;
        end else if (launch) begin
            spike_cnt <= 16'd0;
        end else if (pix_rd && hit) begin
            spike_cnt <= spike_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ips_spike_encoder.sv
// Purpose : self-checking bench for ips_spike_encoder (defaults N_IN=16, ADDR_W=4, PIX_W=8).
// Latency : expects valid_ips 17 cycles after the launch edge.
// Backpr. : n/a; the bench memory answers every read.

module tb_ips_spike_encoder;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_ips = 1'b0;
    logic        pix_rd;
    logic [3:0]  pix_addr;
    logic [7:0]  pix_data;
    logic [15:0] spike_vec;
    logic        valid_ips;
    logic        busy;
`ifdef IPS_SPIKE_COUNT_EN
    logic [15:0] spike_cnt;
`endif

    always #5 clk = ~clk;

    ips_spike_encoder #(
        .N_IN   (16),
        .ADDR_W (4),
        .PIX_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_ips (start_ips),
        .pix_rd    (pix_rd),
        .pix_addr  (pix_addr),
        .pix_data  (pix_data),
        .spike_vec (spike_vec),
        .valid_ips (valid_ips),
        .busy      (busy)
`ifdef IPS_SPIKE_COUNT_EN
        ,
        .spike_cnt (spike_cnt)
`endif
    );

    // Pixel memory: data for the address presented at a rising edge is
    // available before the following rising edge.
    logic [7:0] mem [N];
    always @(negedge clk) begin
        if (pix_rd) pix_data <= mem[pix_addr];
    end

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] mlfsr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference: one run compares pixel i against the low byte of the
    // i-th random number, the generator stepping once per pixel.
    task automatic model_run(output logic [15:0] v, output int cnt);
        v = '0;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] > mlfsr[7:0]) begin
                v[i] = 1'b1;
                cnt++;
            end
            mlfsr = lfsr_step(mlfsr);
        end
    endtask

    function automatic logic [31:0] cur_cnt();
`ifdef IPS_SPIKE_COUNT_EN
        return {16'h0, spike_cnt};
`else
        return 32'h0;
`endif
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".pix_rd"},    pix_rd,    0);
        chk({tag, ".pix_addr"},  pix_addr,  0);
        chk({tag, ".spike_vec"}, spike_vec, 0);
        chk({tag, ".valid_ips"}, valid_ips, 0);
        chk({tag, ".busy"},      busy,      0);
`ifdef IPS_SPIKE_COUNT_EN
        chk({tag, ".spike_cnt"}, spike_cnt, 0);
`endif
    endtask

    task automatic do_reset(input bit check);
        rst_n     = 1'b0;
        start_ips = 1'b0;
        mlfsr     = 16'hACE1;
        @(posedge clk); #1;
        if (check) chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Called one time unit after the launch edge (edge 0). c counts edges
    // after launch; start_ips is pulsed before edge `spur` to probe the
    // ignore-while-busy rule.
    task automatic wait_done(input int spur, input bit stop_at_valid,
                             output int lat, output int nvalid, output int nrd,
                             output bit seq_ok, output logic [15:0] vec,
                             output logic [31:0] cnt);
        int ea;
        ea = 0; lat = -1; nvalid = 0; nrd = 0; seq_ok = 1'b1; vec = '0; cnt = '0;
        for (int c = 1; c <= 24; c++) begin
            start_ips = (c == spur);
            @(posedge clk); #1;
            if (pix_rd) begin
                if (pix_addr != 4'(ea)) seq_ok = 1'b0;
                ea++;
                nrd++;
            end
            if (busy !== (c <= N)) seq_ok = 1'b0;
            if (valid_ips) begin
                nvalid++;
                if (lat < 0) begin
                    lat = c;
                    vec = spike_vec;
                    cnt = cur_cnt();
                end
                if (stop_at_valid) break;
            end
            if (lat > 0 && c >= lat + 3) break;
        end
        start_ips = 1'b0;
    endtask

    task automatic run_check(input string tag, input int spur,
                             input logic [15:0] ev, input int ec);
        int lat, nv, nrd;
        bit sok;
        logic [15:0] vec;
        logic [31:0] cnt;
        start_ips = 1'b1;
        @(posedge clk); #1;
        wait_done(spur, 1'b0, lat, nv, nrd, sok, vec, cnt);
        chk({tag, ".latency"},   lat, 17);
        chk({tag, ".n_valid"},   nv,  1);
        chk({tag, ".n_pix_rd"},  nrd, N);
        chk({tag, ".addr_busy"}, sok, 1);
        chk({tag, ".spike_vec"}, vec, ev);
        chk({tag, ".vec_hold"},  spike_vec, ev);
`ifdef IPS_SPIKE_COUNT_EN
        chk({tag, ".spike_cnt"}, cnt, ec);
`else
        chk({tag, ".no_cnt"},    cnt + 32'(ec) - 32'($countones(vec)), 32'(ec) - 32'($countones(ev)));
`endif
    endtask

    typedef struct {
        logic [7:0]  p0;
        logic [7:0]  p1;
        logic [15:0] vec;
    } vec_t;

    initial begin
        vec_t        tbl [6];
        logic [15:0] ev, ev2;
        int          ec, ec2, lat, nv, nrd, nvr;
        bit          sok;
        logic [15:0] vec;
        logic [31:0] cnt;

        // First two random numbers: 0xACE1 (rnd 0xE1), 0xE270 (rnd 0x70).
        tbl[0] = '{8'd0,   8'd0,    16'h0000};
        tbl[1] = '{8'd226, 8'd0,    16'h0001};
        tbl[2] = '{8'd225, 8'd0,    16'h0000};
        tbl[3] = '{8'd255, 8'h71,   16'h0003};
        tbl[4] = '{8'd0,   8'h70,   16'h0000};
        tbl[5] = '{8'd0,   8'h71,   16'h0002};

        for (int t = 0; t < 6; t++) begin
            do_reset(t == 0);
            for (int i = 0; i < N; i++) mem[i] = 8'd0;
            mem[0] = tbl[t].p0;
            mem[1] = tbl[t].p1;
            run_check($sformatf("tbl%0d", t), 0, tbl[t].vec, $countones(tbl[t].vec));
        end

        // All pixels at full scale.
        do_reset(1'b0);
        for (int i = 0; i < N; i++) mem[i] = 8'd255;
        model_run(ev, ec);
        run_check("all255", 0, ev, ec);

        // Random pixels, LFSR continuing across time units, stray starts while busy.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
            model_run(ev, ec);
            run_check($sformatf("rand%0d", r), $urandom_range(1, 17), ev, ec);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end

        // Back-to-back: start during the valid_ips cycle.
        do_reset(1'b0);
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
        model_run(ev, ec);
        model_run(ev2, ec2);
        start_ips = 1'b1;
        @(posedge clk); #1;
        wait_done(0, 1'b1, lat, nv, nrd, sok, vec, cnt);
        chk("b2b.first_latency", lat, 17);
        chk("b2b.first_vec", vec, ev);
        start_ips = 1'b1;
        @(posedge clk); #1;
        wait_done(0, 1'b0, lat, nv, nrd, sok, vec, cnt);
        chk("b2b.second_latency", lat, 17);
        chk("b2b.second_addr_busy", sok, 1);
        chk("b2b.second_n_pix_rd", nrd, N);
        chk("b2b.second_vec", vec, ev2);

        // Reset in the middle of a run.
        do_reset(1'b0);
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
        start_ips = 1'b1;
        @(posedge clk); #1;
        start_ips = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero("midrst");
        nvr = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (valid_ips) nvr++;
        end
        chk("midrst.no_valid", nvr, 0);
        rst_n = 1'b1;
        mlfsr = 16'hACE1;
        for (int i = 0; i < N; i++) mem[i] = 8'd0;
        mem[0] = 8'd226;
        run_check("after_rst", 0, 16'h0001, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
